// File: rtl/systolic_gemm_engine.sv
// Output-stationary systolic GEMM engine: C(NxM) = A(NxK) x B(KxM).
// A columns and B rows stream in together, are skewed so that matching
// operands meet on the anti-diagonal, and each PE accumulates its C
// element. Results are then read out one element per handshake.
module systolic_gemm_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 32,
  parameter int N          = 4,
  parameter int M          = 4,
  parameter int KMAX       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [$clog2(KMAX+1)-1:0] k_len,
  input  logic [N*DATA_WIDTH-1:0]   a_data,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [M*DATA_WIDTH-1:0]   b_data,
  input  logic                      b_valid,
  output logic                      b_ready,
  output logic [ACC_WIDTH-1:0]      c_data,
  output logic [$clog2(N)-1:0]      c_row,
  output logic [$clog2(M)-1:0]      c_col,
  output logic                      c_valid,
  input  logic                      c_ready,
  output logic                      busy,
  output logic                      done
);

  localparam int KW        = $clog2(KMAX + 1);
  localparam int RW        = $clog2(N);
  localparam int CW        = $clog2(M);
  // Zero-operand steps needed to push the last beat through the skew
  // and across the whole array.
  localparam int FLUSH_LEN = N + M - 1;
  localparam int FW        = $clog2(FLUSH_LEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [KW-1:0]   beat_q, beat_d;
  logic [FW-1:0]   flush_q, flush_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic            done_q, done_d;

  logic            clear;      // new job accepted: wipe array state
  logic            beat;       // joint A/B beat accepted in LOAD
  logic            step;       // array advances this cycle
  logic [KW-1:0]   k_sat;

  logic [DATA_WIDTH-1:0] a_inj   [N];
  logic [DATA_WIDTH-1:0] b_inj   [M];
  logic [DATA_WIDTH-1:0] a_bus   [N][M];  // A operand seen by PE(i,j)
  logic [DATA_WIDTH-1:0] b_bus   [N][M];  // B operand seen by PE(i,j)
  logic [ACC_WIDTH-1:0]  acc_mat [N][M];

  genvar gi, gj;

  // Sign-extend (or truncate) an operand to accumulator width; the low
  // ACC_WIDTH bits of the product are the same either way.
  function automatic logic signed [ACC_WIDTH-1:0] sx(input logic [DATA_WIDTH-1:0] v);
    return ACC_WIDTH'($signed(v));
  endfunction

  assign clear = (state_q == IDLE) && start;
  assign beat  = (state_q == LOAD) && a_valid && b_valid;
  assign step  = beat || (state_q == FLUSH);
  assign k_sat = (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
      row_q   <= row_d;
      col_q   <= col_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: job sequencing, beat/flush counting, drain walk
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    row_d   = row_q;
    col_d   = col_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = k_sat;
          beat_d  = '0;
          flush_d = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = (k_sat == '0) ? DRAIN : LOAD;
        end
      end
      LOAD: begin
        if (beat) begin
          if (beat_q == k_q - KW'(1)) begin
            state_d = FLUSH;
            flush_d = '0;
          end else begin
            beat_d = beat_q + KW'(1);
          end
        end
      end
      FLUSH: begin
        if (flush_q == FW'(FLUSH_LEN - 1)) begin
          state_d = DRAIN;
        end else begin
          flush_d = flush_q + FW'(1);
        end
      end
      DRAIN: begin
        if (c_ready) begin
          if (row_q == RW'(N - 1) && col_q == CW'(M - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            row_d   = '0;
            col_d   = '0;
          end else if (col_q == CW'(M - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Streams are only ready together: each side waits on the other's valid
  assign a_ready = (state_q == LOAD) && b_valid;
  assign b_ready = (state_q == LOAD) && a_valid;
  assign c_valid = (state_q == DRAIN);
  assign c_row   = row_q;
  assign c_col   = col_q;
  assign c_data  = (state_q == DRAIN) ? acc_mat[row_q][col_q] : '0;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

  // Operand injection: live data while loading, zeros while flushing
  for (gi = 0; gi < N; gi++) begin : g_a_inj
    assign a_inj[gi] = (state_q == LOAD) ? a_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
  end
  for (gj = 0; gj < M; gj++) begin : g_b_inj
    assign b_inj[gj] = (state_q == LOAD) ? b_data[gj*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  // Row skew for A: row i is delayed i steps before reaching column 0
  for (gi = 0; gi < N; gi++) begin : g_a_skew
    if (gi == 0) begin : g_direct
      assign a_bus[0][0] = a_inj[0];
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] sk_q [gi];
      // Delay line advancing only with the array
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          for (int d = 0; d < gi; d++) sk_q[d] <= '0;
        end else if (step) begin
          sk_q[0] <= a_inj[gi];
          for (int d = 1; d < gi; d++) sk_q[d] <= sk_q[d-1];
        end
      end
      assign a_bus[gi][0] = sk_q[gi-1];
    end
  end

  // Column skew for B: column j is delayed j steps before reaching row 0
  for (gj = 0; gj < M; gj++) begin : g_b_skew
    if (gj == 0) begin : g_direct
      assign b_bus[0][0] = b_inj[0];
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] sk_q [gj];
      // Delay line advancing only with the array
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          for (int d = 0; d < gj; d++) sk_q[d] <= '0;
        end else if (step) begin
          sk_q[0] <= b_inj[gj];
          for (int d = 1; d < gj; d++) sk_q[d] <= sk_q[d-1];
        end
      end
      assign b_bus[0][gj] = sk_q[gj-1];
    end
  end

  // Processing elements: accumulate locally, forward A right and B down
  for (gi = 0; gi < N; gi++) begin : g_row
    for (gj = 0; gj < M; gj++) begin : g_pe
      logic [ACC_WIDTH-1:0] acc_q;

      // Multiply-accumulate, wrapping at accumulator width
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          acc_q <= '0;
        end else if (step) begin
          acc_q <= acc_q + ACC_WIDTH'(sx(a_bus[gi][gj]) * sx(b_bus[gi][gj]));
        end
      end
      assign acc_mat[gi][gj] = acc_q;

      // The last column has no right-hand neighbour, so no A pass register
      if (gj < M - 1) begin : g_pass_a
        logic [DATA_WIDTH-1:0] a_q;
        // Hand A to the neighbour on the right
        always_ff @(posedge clk) begin
          if (rst || clear) a_q <= '0;
          else if (step)    a_q <= a_bus[gi][gj];
        end
        assign a_bus[gi][gj+1] = a_q;
      end

      // The last row has no neighbour below, so no B pass register
      if (gi < N - 1) begin : g_pass_b
        logic [DATA_WIDTH-1:0] b_q;
        // Hand B to the neighbour below
        always_ff @(posedge clk) begin
          if (rst || clear) b_q <= '0;
          else if (step)    b_q <= b_bus[gi][gj];
        end
        assign b_bus[gi+1][gj] = b_q;
      end
    end
  end

endmodule
